// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read-channel arbiter (IFU = m0, LSU = m1) in front of a single SRAM slave.
// One transaction in flight; ties resolved round-robin against the last completed owner.
module axi_rd_arbiter (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] m0_araddr,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    output logic [31:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    output logic        m0_rvalid,
    input  logic        m0_rready,

    input  logic [31:0] m1_araddr,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    output logic [31:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    output logic        m1_rvalid,
    input  logic        m1_rready,

    output logic [31:0] s_araddr,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rvalid,
    output logic        s_rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   owner, owner_nxt;
    logic   last_grant, last_grant_nxt;
    logic   grant;
    logic   own_arvalid;
    logic   own_rready;

    // With both masters requesting, the one that did not complete last wins.
    assign grant       = (m0_arvalid && m1_arvalid) ? ~last_grant : m1_arvalid;
    assign own_arvalid = owner ? m1_arvalid : m0_arvalid;
    assign own_rready  = owner ? m1_rready  : m0_rready;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // NOTE: every output and next-state value gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;

        s_araddr   = 32'h0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m0_arready = 1'b0;
        m0_rdata   = 32'h0;
        m0_rresp   = 2'b00;
        m0_rvalid  = 1'b0;
        m1_arready = 1'b0;
        m1_rdata   = 32'h0;
        m1_rresp   = 2'b00;
        m1_rvalid  = 1'b0;

        case (state)
            IDLE: begin
                // Grant is registered; arready never depends on arvalid here.
                if (m0_arvalid || m1_arvalid) begin
                    owner_nxt = grant;
                    state_nxt = ADDR;
                end
            end

            ADDR: begin
                s_araddr  = owner ? m1_araddr : m0_araddr;
                s_arvalid = own_arvalid;
                if (owner) m1_arready = s_arready;
                else       m0_arready = s_arready;
                if (own_arvalid && s_arready)
                    state_nxt = DATA;
            end

            DATA: begin
                s_rready = own_rready;
                if (owner) begin
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                    m1_rvalid = s_rvalid;
                end else begin
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                    m0_rvalid = s_rvalid;
                end
                if (s_rvalid && own_rready) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = owner;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: behavioural SRAM slave with programmable
// read latency, two master driver tasks, and a negedge monitor for grant order.
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_araddr, m1_araddr, s_araddr;
    logic        m0_arvalid, m1_arvalid, s_arvalid;
    logic        m0_arready, m1_arready, s_arready;
    logic [31:0] m0_rdata, m1_rdata, s_rdata;
    logic [1:0]  m0_rresp, m1_rresp, s_rresp;
    logic        m0_rvalid, m1_rvalid, s_rvalid;
    logic        m0_rready, m1_rready, s_rready;

    int n_run  = 0;
    int n_fail = 0;

    axi_rd_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .m0_araddr (m0_araddr),
        .m0_arvalid(m0_arvalid),
        .m0_arready(m0_arready),
        .m0_rdata  (m0_rdata),
        .m0_rresp  (m0_rresp),
        .m0_rvalid (m0_rvalid),
        .m0_rready (m0_rready),
        .m1_araddr (m1_araddr),
        .m1_arvalid(m1_arvalid),
        .m1_arready(m1_arready),
        .m1_rdata  (m1_rdata),
        .m1_rresp  (m1_rresp),
        .m1_rvalid (m1_rvalid),
        .m1_rready (m1_rready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return a[5:4];
    endfunction

    // Behavioural SRAM: rvalid rises slv_delay edges after the AR handshake.
    int          slv_delay = 2;
    int          slv_cnt   = 0;
    logic [31:0] slv_addr  = 32'h0;
    initial begin : slave_model
        logic        ar_hs, r_hs;
        logic [31:0] hs_addr;
        s_arready = 1'b1;
        s_rvalid  = 1'b0;
        s_rdata   = 32'h0;
        s_rresp   = 2'b00;
        forever begin
            @(negedge clk);
            ar_hs   = s_arvalid && s_arready;
            r_hs    = s_rvalid && s_rready;
            hs_addr = s_araddr;
            @(posedge clk); #1;
            if (!reset) begin
                s_rvalid = 1'b0; s_rdata = 32'h0; s_rresp = 2'b00; slv_cnt = 0;
            end else begin
                if (r_hs) begin
                    s_rvalid = 1'b0; s_rdata = 32'h0; s_rresp = 2'b00;
                end
                if (ar_hs) begin
                    slv_cnt  = slv_delay;
                    slv_addr = hs_addr;
                end else if (slv_cnt > 1) begin
                    slv_cnt--;
                end else if (slv_cnt == 1) begin
                    slv_cnt  = 0;
                    s_rvalid = 1'b1;
                    s_rdata  = exp_data(slv_addr);
                    s_rresp  = exp_resp(slv_addr);
                end
            end
        end
    end

    // Monitor: AR-handshake log and sticky counters, sampled mid-cycle.
    int          cyc = 0;
    int          grants[$];
    logic [31:0] ar_addrs[$];
    int          ar_cyc[$];
    int          r_cyc0 = 0, r_cnt1 = 0, m1_nz = 0, bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (s_arvalid && s_arready) begin
            grants.push_back(m1_arready ? 1 : 0);
            ar_addrs.push_back(s_araddr);
            ar_cyc.push_back(cyc);
        end
        if (m0_rvalid && m0_rready) r_cyc0 <= cyc;
        if (m1_rvalid) r_cnt1 <= r_cnt1 + 1;
        if (m1_arready || m1_rvalid || m1_rdata != 32'h0 || m1_rresp != 2'b00) m1_nz <= m1_nz + 1;
        if ((m0_arready && m1_arready) || (m0_rvalid && m1_rvalid) ||
            (!m0_rvalid && (m0_rdata != 32'h0 || m0_rresp != 2'b00)) ||
            (!m1_rvalid && (m1_rdata != 32'h0 || m1_rresp != 2'b00)))
            bad <= bad + 1;
    end

    int g_base = 0;
    task automatic mark();
        g_base = grants.size();
    endtask

    function automatic int n_grants();
        return grants.size() - g_base;
    endfunction

    function automatic logic [7:0] grant_seq();
        logic [7:0] v = 8'h0;
        for (int i = 0; i < 8; i++)
            if (g_base + i < grants.size()) v[i] = grants[g_base + i][0];
        return v;
    endfunction

    function automatic logic [31:0] ar_addr_at(input int k);
        return (g_base + k < ar_addrs.size()) ? ar_addrs[g_base + k] : 32'hDEAD_DEAD;
    endfunction

    function automatic int ar_cyc_at(input int k);
        return (g_base + k < ar_cyc.size()) ? ar_cyc[g_base + k] : -1;
    endfunction

    function automatic logic [7:0] ctrl_outs();
        return {m0_arready, m0_rvalid, m0_rresp, m1_arready, m1_rvalid, m1_rresp} |
               {6'b0, s_arvalid, s_rready};
    endfunction

    task automatic drive_ar(input int m, input logic v, input logic [31:0] a);
        if (m == 0) begin m0_arvalid = v; m0_araddr = a; end
        else        begin m1_arvalid = v; m1_araddr = a; end
    endtask

    task automatic drive_r(input int m, input logic v);
        if (m == 0) m0_rready = v;
        else        m1_rready = v;
    endtask

    // One read from master m; n counts cycles from the call (cycle 0 = first IDLE).
    task automatic m_read(input int m, input logic [31:0] addr, input int hold,
                          output logic [31:0] data, output logic [1:0] resp,
                          output int rv_n, output int hs_n, output int stalls);
        int   n = 0, held = 0;
        logic hs = 1'b0, seen, rdy;
        data = 32'h0; resp = 2'b00; rv_n = -1; hs_n = -1; stalls = 0;
        drive_ar(m, 1'b1, addr);
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = (m == 0) ? m0_arready : m1_arready;
            @(posedge clk); #1;
            n++;
        end
        drive_ar(m, 1'b0, 32'h0);
        drive_r(m, hold == 0);
        hs = 1'b0;
        while (!hs && n < 200) begin
            @(negedge clk);
            seen = (m == 0) ? m0_rvalid : m1_rvalid;
            rdy  = (m == 0) ? m0_rready : m1_rready;
            if (seen) begin
                if (rv_n < 0) rv_n = n;
                data = (m == 0) ? m0_rdata : m1_rdata;
                resp = (m == 0) ? m0_rresp : m1_rresp;
                if (rdy) begin
                    hs   = 1'b1;
                    hs_n = n;
                end else begin
                    held++;
                    if (!s_rready) stalls++;
                end
            end
            @(posedge clk); #1;
            n++;
            if (held >= hold) drive_r(m, 1'b1);
        end
        drive_r(m, 1'b0);
        check($sformatf("m%0d_read_done_%0h", m, addr), hs, 1'b1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [31:0] d0, d1;
        logic [1:0]  r0, r1;
        int          rv0, hs0, st0, rv1, hs1, st1, base;
        logic        hs;
        int          k;

        reset = 1'b0;
        m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1; m0_rready = 1'b1;
        m1_araddr = 32'h0;         m1_arvalid = 1'b1; m1_rready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", ctrl_outs(), 8'h0);
        check("reset_rdata", {m0_rdata, m1_rdata}, 64'h0);
        check("reset_araddr", s_araddr, 32'h0);
        @(posedge clk); #1;
        m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;

        // m0 alone, slave latency 2: 1 IDLE + 1 ADDR + 2 -> rvalid in cycle 4.
        mark();
        base = m1_nz;
        m_read(0, 32'h8000_0000, 0, d0, r0, rv0, hs0, st0);
        check("t1_rdata", d0, 32'hDA5A_0F0F);
        check("t1_rresp", r0, 2'b00);
        check("t1_latency", rv0, 4);
        check("t1_grants", {n_grants(), 24'h0, grant_seq()}, {32'd1, 32'h0});
        check("t1_s_araddr", ar_addr_at(0), 32'h8000_0000);
        check("t1_m1_quiet", m1_nz - base, 0);

        // Fresh reset, simultaneous requests: m0 first, m1 after one IDLE cycle.
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        mark();
        fork
            m_read(0, 32'h8000_0010, 0, d0, r0, rv0, hs0, st0);
            m_read(1, 32'h8000_0100, 0, d1, r1, rv1, hs1, st1);
        join
        check("t2_order", {n_grants(), 24'h0, grant_seq()}, {32'd2, 32'h2});
        check("t2_m0_data", {r0, d0}, {2'b01, 32'hDA5A_0F1F});
        check("t2_m1_data", {r1, d1}, {2'b00, 32'hDA5A_0E0F});
        check("t2_m1_addr", ar_addr_at(1), 32'h8000_0100);
        check("t2_idle_gap", ar_cyc_at(1) - r_cyc0, 2);

        // Both requesting continuously: m0, m1, m0, m1.
        mark();
        fork
            for (int i = 0; i < 2; i++)
                m_read(0, 32'h8000_0200 + 32'(i * 4), 0, d0, r0, rv0, hs0, st0);
            for (int j = 0; j < 2; j++)
                m_read(1, 32'h8000_0220 + 32'(j * 16), 0, d1, r1, rv1, hs1, st1);
        join
        check("t3_order", {n_grants(), 24'h0, grant_seq()}, {32'd4, 32'ha});
        check("t3_m1_last", {r1, d1}, {2'b11, 32'hDA5A_0D3F});

        // Owner stalls rready for 5 cycles with rvalid up.
        mark();
        m_read(0, 32'h8000_0300, 5, d0, r0, rv0, hs0, st0);
        check("t4_stall_cycles", st0, 5);
        check("t4_first_rvalid", rv0, 4);
        check("t4_handshake", hs0, 9);
        check("t4_rdata", d0, 32'hDA5A_0C0F);

        // m1 requests while m0 sits in DATA: held off until m0 completes.
        slv_delay = 3;
        mark();
        fork
            m_read(0, 32'h8000_0400, 0, d0, r0, rv0, hs0, st0);
            begin
                repeat (3) begin @(posedge clk); #1; end
                m_read(1, 32'h8000_0500, 0, d1, r1, rv1, hs1, st1);
            end
        join
        check("t5_order", {n_grants(), 24'h0, grant_seq()}, {32'd2, 32'h2});
        check("t5_m1_wait", ar_cyc_at(1) - r_cyc0, 2);
        check("t5_m1_data", d1, 32'hDA5A_0A0F);

        // Reset while m1 is in DATA, then a normal m1 read.
        slv_delay = 4;
        base = r_cnt1;
        m1_araddr = 32'h8000_0600; m1_arvalid = 1'b1;
        hs = 1'b0; k = 0;
        while (!hs && k < 20) begin
            @(negedge clk);
            hs = m1_arready;
            @(posedge clk); #1;
            k++;
        end
        check("t6_ar_hs", hs, 1'b1);
        m1_arvalid = 1'b0; m1_araddr = 32'h0; m1_rready = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("t6_reset_ctrl", ctrl_outs(), 8'h0);
        check("t6_reset_rdata", {m0_rdata, m1_rdata}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        m1_rready = 1'b0;
        reset = 1'b1;
        check("t6_no_rvalid", r_cnt1 - base, 0);
        @(posedge clk); #1;
        slv_delay = 2;
        mark();
        m_read(1, 32'h8000_0700, 0, d1, r1, rv1, hs1, st1);
        check("t6_after_data", d1, 32'hDA5A_080F);
        check("t6_after_latency", rv1, 4);
        check("t6_after_owner", {n_grants(), 24'h0, grant_seq()}, {32'd1, 32'h1});

        check("non_owner_clean", bad, 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
